flex_fifo: RTL
==============

FLEX_FIFO -- requirements
Module: flex_fifo

Interface
REQ-001 SHALL have parameter DataWidth, default 8, meaning the payload width in bits.
REQ-002 SHALL have parameter Depth, default 16, meaning the number of entries; it must be a power of 2 and at least 2.
REQ-003 SHALL have parameter OverwriteOldest, default 1'b0, meaning the overflow mode: 0 = drop incoming, 1 = discard oldest.
REQ-004 SHALL have parameter AlmostFullThresh, default Depth-2, meaning almost_full asserts when count >= this value.
REQ-005 SHALL have parameter AlmostEmptyThresh, default 1, meaning almost_empty asserts when count <= this value.
REQ-006 SHALL have parameter StatWidth, default 8, meaning the width of the statistics counters.
REQ-007 SHALL have port clk, input, 1 bit: clock, all state on the rising edge.
REQ-008 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-009 SHALL have port push, input, 1 bit: write request.
REQ-010 SHALL have port data, input, DataWidth bits: write payload.
REQ-011 SHALL have port pop, input, 1 bit: read acknowledge; q is consumed on this edge.
REQ-012 SHALL have port flush, input, 1 bit: synchronous clear of contents.
REQ-013 SHALL have port clr_stats, input, 1 bit: synchronous clear of ovf_cnt and unf_cnt.
REQ-014 SHALL have port q, output, DataWidth bits: head entry (show-ahead, combinational from storage).
REQ-015 SHALL have ports full, empty, almost_full and almost_empty, outputs, 1 bit each: level flags.
REQ-016 SHALL have port count, output, $clog2(Depth)+1 bits: current occupancy, range 0..Depth.
REQ-017 SHALL have ports overflow and underflow, outputs, 1 bit each: registered one-cycle event pulses.
REQ-018 SHALL have ports ovf_cnt and unf_cnt, outputs, StatWidth bits each: saturating event counters.

Function
REQ-019 SHALL keep read and write pointers of $clog2(Depth)+1 bits that wrap modulo 2*Depth; count = wr_ptr - rd_ptr (modulo arithmetic).
REQ-020 SHALL drive the level flags combinationally from the pointers: empty = (count==0), full = (count==Depth), almost_full = (count>=AlmostFullThresh), almost_empty = (count<=AlmostEmptyThresh).
REQ-021 SHALL handle push while not full: store data at wr_ptr and increment wr_ptr; the entry is visible on q the next cycle if the FIFO was empty.
REQ-022 SHALL handle pop while not empty: increment rd_ptr.
REQ-023 SHALL handle push+pop in the same cycle while not empty and not full as both succeeding, leaving count unchanged.
REQ-024 SHALL handle push+pop in the same cycle while full as both succeeding normally, with no overflow.
REQ-025 SHALL handle push+pop in the same cycle while empty as follows: the pop is an underflow, the push succeeds, and count becomes 1.
REQ-026 SHALL handle push while full without a same-cycle pop, with OverwriteOldest=0, as follows: data is discarded, the pointers are unchanged, and it counts as an overflow.
REQ-027 SHALL handle push while full without a same-cycle pop, with OverwriteOldest=1, as follows: store at wr_ptr, increment both pointers, count stays at Depth, the oldest entry is lost, and it counts as an overflow.
REQ-028 SHALL handle pop while empty as follows: the pointers are unchanged, q keeps showing the last-read slot, and it counts as an underflow.
REQ-029 SHALL pulse overflow/underflow high for exactly one cycle, in the cycle after the offending edge.
REQ-030 SHALL increment ovf_cnt/unf_cnt by 1 per event and saturate at all-ones with no wrap.
REQ-031 SHALL give flush priority over push and pop in the same cycle: both pointers go to 0, storage is untouched, and no overflow or underflow is flagged.
REQ-032 SHALL give clr_stats priority over a same-cycle increment, zeroing both counters; the pulses are unaffected.
REQ-033 SHALL NOT reset the storage array; q is undefined until the first write and is don't-care while empty.

Reset
REQ-034 SHALL on rst_n low asynchronously set both pointers to 0, ovf_cnt = unf_cnt = 0, and overflow = underflow = 0.
REQ-035 SHALL show empty=1, almost_empty=1, full=0, almost_full=0 and count=0 while in reset and after reset.
REQ-036 SHALL on reset asserted mid-operation discard all contents immediately and require no flush afterward.

Verification (Depth=4, DataWidth=8, AlmostFullThresh=3, AlmostEmptyThresh=1)
REQ-037 SHALL cover: push 0x11,0x22,0x33,0x44 -> full=1, count=4, almost_full=1; then 4 pops -> q reads 0x11,0x22,0x33,0x44, then empty=1.
REQ-038 SHALL cover, with OverwriteOldest=0: fill with 0x01..0x04 then push 0x55 -> overflow pulses once, ovf_cnt=1, and drain yields 0x01..0x04.
REQ-039 SHALL cover, with OverwriteOldest=1: fill with 0x01..0x04 then push 0x55 -> overflow pulses once, count=4, and drain yields 0x02,0x03,0x04,0x55.
REQ-040 SHALL cover: pop while empty three times -> underflow pulses 3 times, unf_cnt=3, pointers unchanged; then clr_stats -> unf_cnt=0.
REQ-041 SHALL cover: push+pop together while empty with data 0x7E -> underflow pulses once, count=1, q=0x7E; and push+pop while full -> count stays 4 with no overflow.
REQ-042 SHALL cover: with 3 entries, flush+push in the same cycle -> count=0, empty=1; and rst_n low for one cycle mid-stream -> all outputs at their reset values and the counters at 0.

Source files
------------

// File: rtl/flex_fifo.sv
// Synchronous show-ahead FIFO with selectable overflow policy, level flags,
// registered overflow/underflow pulses and saturating event counters.
module flex_fifo #(
  parameter int unsigned DataWidth         = 8,
  parameter int unsigned Depth             = 16,
  parameter bit          OverwriteOldest   = 1'b0,
  parameter int unsigned AlmostFullThresh  = Depth - 2,
  parameter int unsigned AlmostEmptyThresh = 1,
  parameter int unsigned StatWidth         = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [DataWidth-1:0]     data,
  input  logic                     pop,
  input  logic                     flush,
  input  logic                     clr_stats,
  output logic [DataWidth-1:0]     q,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(Depth):0]   count,
  output logic                     overflow,
  output logic                     underflow,
  output logic [StatWidth-1:0]     ovf_cnt,
  output logic [StatWidth-1:0]     unf_cnt
);

  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned PW = AW + 1;
  localparam logic [PW-1:0]        PtrOne  = PW'(1);
  localparam logic [StatWidth-1:0] StatOne = StatWidth'(1);

  logic [DataWidth-1:0] mem_q [Depth];
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic                 overflow_q, overflow_d;
  logic                 underflow_q, underflow_d;
  logic [StatWidth-1:0] ovf_cnt_q, ovf_cnt_d;
  logic [StatWidth-1:0] unf_cnt_q, unf_cnt_d;
  logic                 mem_we;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign count        = wr_ptr_q - rd_ptr_q;
  assign empty        = (count == '0);
  assign full         = (32'(count) == Depth);
  assign almost_full  = (32'(count) >= AlmostFullThresh);
  assign almost_empty = (32'(count) <= AlmostEmptyThresh);
  assign q            = mem_q[rd_ptr_q[AW-1:0]];

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign ovf_cnt   = ovf_cnt_q;
  assign unf_cnt   = unf_cnt_q;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    mem_we      = 1'b0;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      overflow_d  = push && full && !pop;
      underflow_d = pop && empty;
      // A pop while full frees the slot the push writes into on the same edge.
      if (push && (!full || pop)) begin
        mem_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + PtrOne;
      end else if (overflow_d && OverwriteOldest) begin
        mem_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + PtrOne;
        rd_ptr_d = rd_ptr_q + PtrOne;
      end
      if (pop && !empty) begin
        rd_ptr_d = rd_ptr_q + PtrOne;
      end
    end
  end

  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    unf_cnt_d = unf_cnt_q;
    if (clr_stats) begin
      ovf_cnt_d = '0;
      unf_cnt_d = '0;
    end else begin
      if (overflow_d && (ovf_cnt_q != '1)) ovf_cnt_d = ovf_cnt_q + StatOne;
      if (underflow_d && (unf_cnt_q != '1)) unf_cnt_d = unf_cnt_q + StatOne;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      ovf_cnt_q   <= '0;
      unf_cnt_q   <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      ovf_cnt_q   <= ovf_cnt_d;
      unf_cnt_q   <= unf_cnt_d;
    end
  end

  // NOTE: storage has no reset; the pointers alone define validity, which keeps it mappable to RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wr_ptr_q[AW-1:0]] <= data;
    end
  end

endmodule
